// File: rtl/if_id_hazard_ctrl.sv
// IF/ID sequencing controller: load-use stalls, taken-branch flushes and
// imem wait states with a timeout watchdog. Optional counters: HAZARD_STATS_EN.
module if_id_hazard_ctrl #(
  parameter int REG_ADDR_W   = 5,
  parameter int FLUSH_CYCLES = 1,
  parameter int IMEM_TIMEOUT = 15
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rt,
  input  logic                  id_ex_mem_read,
  input  logic [REG_ADDR_W-1:0] id_ex_rt,
  input  logic                  branch_taken,
  input  logic                  imem_ready,
  output logic                  pc_write,
  output logic                  if_id_write,
  output logic                  if_id_flush,
  output logic                  id_ex_bubble,
  output logic                  if_id_valid,
  output logic                  imem_err,
  output logic [15:0]           stall_count,
  output logic [15:0]           flush_count,
  output logic [2:0]            fsm_state
);

  typedef enum logic [2:0] {
    ST_START    = 3'd0,
    ST_RUN      = 3'd1,
    ST_LU_STALL = 3'd2,
    ST_BR_FLUSH = 3'd3,
    ST_IM_WAIT  = 3'd4
  } state_t;

  localparam logic [1:0] FLUSH_RELOAD = 2'(FLUSH_CYCLES - 1);
  localparam logic [7:0] TIMEOUT_V    = 8'(IMEM_TIMEOUT);

  state_t     state, state_nxt;
  logic [1:0] flush_cnt, flush_cnt_nxt;
  logic [7:0] wait_cnt, wait_cnt_nxt;
  logic       lu;
  logic       lu_stall;

  assign fsm_state = state;

  assign lu = if_id_valid & id_ex_mem_read & (id_ex_rt != '0) &
              ((id_ex_rt == id_rs) | (id_uses_rt & (id_ex_rt == id_rt)));

  // IM_WAIT shares RUN's rules: it only exists so a stalled fetch is visible.
  always_comb begin
    pc_write      = 1'b0;
    if_id_write   = 1'b0;
    if_id_flush   = 1'b1;
    id_ex_bubble  = 1'b1;
    lu_stall      = 1'b0;
    state_nxt     = state;
    flush_cnt_nxt = flush_cnt;
    if (reset) begin
      state_nxt     = ST_START;
      flush_cnt_nxt = 2'd0;
    end else if (state == ST_START) begin
      if (imem_ready) state_nxt = ST_RUN;
    end else if (branch_taken) begin
      pc_write      = 1'b1;
      if_id_write   = 1'b1;
      flush_cnt_nxt = FLUSH_RELOAD;
      state_nxt     = (FLUSH_CYCLES > 1) ? ST_BR_FLUSH : ST_RUN;
    end else begin
      case (state)
        ST_RUN, ST_IM_WAIT: begin
          if_id_flush = 1'b0;
          if (!imem_ready) begin
            state_nxt = ST_IM_WAIT;
          end else if (lu) begin
            lu_stall  = 1'b1;
            state_nxt = ST_LU_STALL;
          end else begin
            pc_write     = 1'b1;
            if_id_write  = 1'b1;
            id_ex_bubble = 1'b0;
            state_nxt    = ST_RUN;
          end
        end
        ST_LU_STALL: begin
          pc_write     = 1'b1;
          if_id_write  = 1'b1;
          if_id_flush  = 1'b0;
          id_ex_bubble = 1'b0;
          state_nxt    = ST_RUN;
        end
        ST_BR_FLUSH: begin
          pc_write    = imem_ready;
          if_id_write = imem_ready;
          if (imem_ready) begin
            if (flush_cnt != 2'd0) flush_cnt_nxt = flush_cnt - 2'd1;
            if (flush_cnt <= 2'd1) state_nxt = ST_RUN;
          end
        end
        default: state_nxt = ST_START;
      endcase
    end
  end

  always_comb begin
    wait_cnt_nxt = wait_cnt;
    if (imem_ready)             wait_cnt_nxt = 8'd0;
    else if (wait_cnt != 8'hFF) wait_cnt_nxt = wait_cnt + 8'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_START;
      flush_cnt   <= 2'd0;
      if_id_valid <= 1'b0;
      wait_cnt    <= 8'd0;
      imem_err    <= 1'b0;
    end else begin
      state     <= state_nxt;
      flush_cnt <= flush_cnt_nxt;
      if (if_id_flush)      if_id_valid <= 1'b0;
      else if (if_id_write) if_id_valid <= 1'b1;
      wait_cnt <= wait_cnt_nxt;
      if (wait_cnt_nxt >= TIMEOUT_V) imem_err <= 1'b1;
    end
  end

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      stall_count <= 16'h0000;
      flush_count <= 16'h0000;
    end else begin
      if (lu_stall && stall_count != 16'hFFFF)    stall_count <= stall_count + 16'd1;
      if (if_id_flush && flush_count != 16'hFFFF) flush_count <= flush_count + 16'd1;
    end
  end
`else
  assign stall_count = 16'h0000;
  assign flush_count = 16'h0000;
`endif

endmodule

// File: tb/tb_if_id_hazard_ctrl.sv
// Bench for if_id_hazard_ctrl: three instances (FLUSH_CYCLES 1..3) share one
// stimulus stream and are compared against a per-instance behavioural model.
module tb_if_id_hazard_ctrl;

  localparam int N = 3;

  // clock / reset
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset;
  logic [4:0] id_rs, id_rt, id_ex_rt;
  logic       id_uses_rt, id_ex_mem_read, branch_taken, imem_ready;

  logic        pc_write_w [N];
  logic        if_id_write_w [N];
  logic        if_id_flush_w [N];
  logic        id_ex_bubble_w [N];
  logic        if_id_valid_w [N];
  logic        imem_err_w [N];
  logic [15:0] stall_count_w [N];
  logic [15:0] flush_count_w [N];
  logic [2:0]  fsm_state_w [N];

  for (genvar g = 0; g < N; g++) begin : g_dut
    if_id_hazard_ctrl #(
      .REG_ADDR_W  (5),
      .FLUSH_CYCLES(g + 1),
      .IMEM_TIMEOUT((g == 0) ? 15 : 5)
    ) u_dut (
      .clock         (clock),
      .reset         (reset),
      .id_rs         (id_rs),
      .id_rt         (id_rt),
      .id_uses_rt    (id_uses_rt),
      .id_ex_mem_read(id_ex_mem_read),
      .id_ex_rt      (id_ex_rt),
      .branch_taken  (branch_taken),
      .imem_ready    (imem_ready),
      .pc_write      (pc_write_w[g]),
      .if_id_write   (if_id_write_w[g]),
      .if_id_flush   (if_id_flush_w[g]),
      .id_ex_bubble  (id_ex_bubble_w[g]),
      .if_id_valid   (if_id_valid_w[g]),
      .imem_err      (imem_err_w[g]),
      .stall_count   (stall_count_w[g]),
      .flush_count   (flush_count_w[g]),
      .fsm_state     (fsm_state_w[g])
    );
  end

  // reference model: "started", remaining flush cycles, post-stall cycle
  bit m_start [N];
  int m_flush_left [N];
  bit m_after [N];
  bit m_valid [N];
  int m_wait [N];
  bit m_err [N];
  int m_stall_n [N];
  int m_flush_n [N];

  logic [3:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      if (n_err <= 40) $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int fc_of(int k);
    return k + 1;
  endfunction

  function automatic int to_of(int k);
    return (k == 0) ? 15 : 5;
  endfunction

  function automatic bit model_lu(int k);
    return m_valid[k] && id_ex_mem_read && (id_ex_rt != 0) &&
           ((id_ex_rt == id_rs) || (id_uses_rt && (id_ex_rt == id_rt)));
  endfunction

  // {pc_write, if_id_write, if_id_flush, id_ex_bubble}
  function automatic logic [3:0] model_ctl(int k);
    if (reset || m_start[k])  return 4'b0011;
    if (branch_taken)         return 4'b1111;
    if (m_flush_left[k] > 0)  return {imem_ready, imem_ready, 2'b11};
    if (m_after[k])           return 4'b1100;
    if (!imem_ready)          return 4'b0001;
    if (model_lu(k))          return 4'b0001;
    return 4'b1100;
  endfunction

  task automatic model_edge(int k, logic [3:0] ctl);
    bit stall_taken;
    if (reset) begin
      m_start[k] = 1; m_flush_left[k] = 0; m_after[k] = 0; m_valid[k] = 0;
      m_wait[k] = 0; m_err[k] = 0; m_stall_n[k] = 0; m_flush_n[k] = 0;
      return;
    end
    stall_taken = !m_start[k] && !branch_taken && m_flush_left[k] == 0 &&
                  !m_after[k] && imem_ready && model_lu(k);
    if (ctl[1] && m_flush_n[k] < 65535) m_flush_n[k]++;
    if (ctl[1]) m_valid[k] = 0;
    else if (ctl[2]) m_valid[k] = 1;
    m_wait[k] = imem_ready ? 0 : ((m_wait[k] < 255) ? m_wait[k] + 1 : 255);
    if (m_wait[k] >= to_of(k)) m_err[k] = 1;
    if (m_start[k]) begin
      if (imem_ready) m_start[k] = 0;
    end else if (branch_taken) begin
      m_flush_left[k] = fc_of(k) - 1;
      m_after[k] = 0;
    end else if (m_flush_left[k] > 0) begin
      if (imem_ready) m_flush_left[k]--;
    end else if (m_after[k]) begin
      m_after[k] = 0;
    end else if (stall_taken) begin
      m_after[k] = 1;
      if (m_stall_n[k] < 65535) m_stall_n[k]++;
    end
  endtask

  // driver: one cycle of stimulus, checks before the edge, model after it
  task automatic step(input bit rst, input bit br, input bit rdy, input bit mr,
                      input bit ur, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] exrt);
    logic [3:0] ctl [N];
    logic [15:0] es, ef;
    @(negedge clock);
    reset = rst; branch_taken = br; imem_ready = rdy; id_ex_mem_read = mr;
    id_uses_rt = ur; id_rs = rs; id_rt = rt; id_ex_rt = exrt;
    #1;
    for (int k = 0; k < N; k++) exp_q.push_back(model_ctl(k));
    for (int k = 0; k < N; k++) begin
      ctl[k] = exp_q.pop_front();
      check($sformatf("ctl[%0d]", k),
            {28'd0, pc_write_w[k], if_id_write_w[k], if_id_flush_w[k], id_ex_bubble_w[k]},
            {28'd0, ctl[k]});
      check($sformatf("valid[%0d]", k), {31'd0, if_id_valid_w[k]}, {31'd0, m_valid[k]});
      check($sformatf("err[%0d]", k), {31'd0, imem_err_w[k]}, {31'd0, m_err[k]});
`ifdef HAZARD_STATS_EN
      es = 16'(m_stall_n[k]); ef = 16'(m_flush_n[k]);
`else
      es = 16'h0; ef = 16'h0;
`endif
      check($sformatf("stall_cnt[%0d]", k), {16'd0, stall_count_w[k]}, {16'd0, es});
      check($sformatf("flush_cnt[%0d]", k), {16'd0, flush_count_w[k]}, {16'd0, ef});
      if (m_start[k] && !rst) check($sformatf("dbg_start[%0d]", k), {29'd0, fsm_state_w[k]}, 32'd0);
    end
    @(posedge clock);
    for (int k = 0; k < N; k++) model_edge(k, ctl[k]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 1, 0, 0, 5'd1, 5'd2, 5'd3);
  endtask

  initial begin
    int low_left;
    bit rst, br, rdy, mr, ur;
    logic [4:0] rs, rt, exrt;
    reset = 1; branch_taken = 0; imem_ready = 1; id_ex_mem_read = 0;
    id_uses_rt = 0; id_rs = 0; id_rt = 0; id_ex_rt = 0;
    for (int k = 0; k < N; k++) begin
      m_start[k] = 1; m_flush_left[k] = 0; m_after[k] = 0; m_valid[k] = 0;
      m_wait[k] = 0; m_err[k] = 0; m_stall_n[k] = 0; m_flush_n[k] = 0;
    end

    // reset, then start-up into RUN
    step(1, 0, 1, 0, 0, 0, 0, 0);
    step(1, 0, 1, 0, 0, 0, 0, 0);
    idle(3);
    // load-use on rs, then with rt == 0, then via rt
    step(0, 0, 1, 1, 0, 5'd5, 5'd7, 5'd5);
    idle(3);
    step(0, 0, 1, 1, 1, 5'd0, 5'd0, 5'd0);
    idle(2);
    step(0, 0, 1, 1, 1, 5'd9, 5'd6, 5'd6);
    idle(3);
    // branch pulse, then branch coincident with load-use
    step(0, 1, 1, 0, 0, 5'd1, 5'd2, 5'd3);
    idle(4);
    step(0, 1, 1, 1, 0, 5'd5, 5'd2, 5'd5);
    idle(4);
    // 15-cycle fetch stall, error stays after recovery, reset clears it
    for (int i = 0; i < 15; i++) step(0, 0, 0, 0, 0, 5'd1, 5'd2, 5'd3);
    idle(3);
    step(1, 0, 1, 0, 0, 0, 0, 0);
    idle(3);
    // reset while flushing
    step(0, 1, 1, 0, 0, 5'd1, 5'd2, 5'd3);
    step(1, 0, 1, 0, 0, 0, 0, 0);
    idle(5);
    // branch during a flush with the fetch stalled
    step(0, 1, 1, 0, 0, 5'd1, 5'd2, 5'd3);
    step(0, 0, 0, 0, 0, 5'd1, 5'd2, 5'd3);
    step(0, 1, 0, 0, 0, 5'd1, 5'd2, 5'd3);
    idle(5);

    // randomized traffic
    low_left = 0;
    for (int i = 0; i < 4000; i++) begin
      rst  = ($urandom_range(0, 299) == 0);
      br   = ($urandom_range(0, 9) == 0);
      if (low_left == 0 && $urandom_range(0, 39) == 0) low_left = $urandom_range(1, 20);
      rdy  = (low_left == 0) ? ($urandom_range(0, 9) != 0) : 1'b0;
      if (low_left > 0) low_left--;
      mr   = $urandom_range(0, 1);
      ur   = $urandom_range(0, 1);
      rs   = 5'($urandom_range(0, 3));
      rt   = 5'($urandom_range(0, 3));
      exrt = 5'($urandom_range(0, 3));
      step(rst, br, rdy, mr, ur, rs, rt, exrt);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
